ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Sequencer for a tile's configuration-flip-flop chain (ccff_head -> ... -> ccff_tail, clocked by prog_clk).
- Accepts bitstream words over a valid/ready stream and serialises them into ccff_head MSB-first, one bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits.
- Optional verify pass rotates the chain non-destructively (tail fed back to head) and compares each bit leaving ccff_tail with a re-streamed expected bitstream.
- Sits between the bitstream source and the tile chain; ccff_shift_en drives the chain's prog_clk gate.

Parameters:
- CHAIN_LEN, 64, number of ccff bits in the chain (>=1).
- W, 32, bitstream word width (>=2).
- CNT_W, 16, mismatch counter width; saturates.

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a pass when in IDLE or DONE, ignored otherwise.
- mode_verify  in  1  sampled with start: 0 = load, 1 = verify.
- abort  in  1  returns to IDLE next cycle from any state; chain contents are then undefined.
- cfg_data  in  W  bitstream word; bit W-1 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
- ccff_head  out  1  serial data into the chain.
- ccff_shift_en  out  1  chain shifts on the next prog_clk edge when 1.
- ccff_tail  in  1  serial data out of the chain.
- busy  out  1  high in LOAD or VERIFY.
- done  out  1  high in DONE; cleared by start or abort.
- err_mismatch  out  1  sticky for the current verify pass.
- mismatch_cnt  out  CNT_W  mismatches counted in the current verify pass.

Behaviour:
- Reset values: state=IDLE; cfg_ready, ccff_shift_en, busy, done, err_mismatch = 0; ccff_head = 0; mismatch_cnt = 0; bit counter = 0; word buffer empty.
- States: IDLE -start-> LOAD or VERIFY (chosen by mode_verify); LOAD/VERIFY -> DONE in the cycle after the CHAIN_LEN-th shift; DONE -start-> LOAD or VERIFY; any state -abort-> IDLE.
- Entering LOAD or VERIFY clears the bit counter, the word buffer, err_mismatch and mismatch_cnt.
- Word buffer: a W-bit shift register plus a bits-left count.
- cfg_ready = busy && (buffer empty || (1 bit left && shifting this cycle)) && bits still required beyond those already buffered. Back-to-back words therefore stream with no bubble.
- Shift cycle: occurs whenever the buffer holds >=1 bit and shifted < CHAIN_LEN.
  - ccff_shift_en = 1 in that cycle.
  - Buffer MSB is presented on the chain input.
  - Bit counter increments.
  - Buffer empty (source stall) -> ccff_shift_en = 0 and the chain holds.
- Load mode: ccff_head is registered. It updates together with ccff_shift_en, so the head bit and enable change in the same cycle.
- Verify mode:
  - ccff_head = ccff_tail (combinational loop-back), so after CHAIN_LEN shifts the chain holds its original contents.
  - On each shift cycle, compare ccff_tail with the buffer MSB (the expected bit).
  - On mismatch: set err_mismatch; increment mismatch_cnt, saturating at 2^CNT_W-1.
- Bit order: the first bit shifted in exits ccff_tail first in a later verify pass, so the same bitstream serves both modes.
- Partial final word: if CHAIN_LEN is not a multiple of W, only the top (CHAIN_LEN mod W) bits of the last word are used; the rest are discarded and the buffer is flushed on entering DONE.
- Latency: first shift occurs one cycle after the first accepted word. DONE is entered 1 cycle after the last shift, with ccff_shift_en = 0 in that cycle.
- Words offered in IDLE or DONE are not accepted (cfg_ready = 0).
- start while busy is ignored. start coincident with abort: abort wins.
- pReset_n asserted mid-pass: immediate return to reset values; ccff_shift_en drops asynchronously.

Decomposition:
- Shared package ccff_loader_pkg:
  - state enum (IDLE, LOAD, VERIFY, DONE);
  - localparams: bit-counter width clog2(CHAIN_LEN+1); words per pass ceil(CHAIN_LEN/W); final-word used bits.
- One sub-module: ccff_word_serializer (W-bit buffer, bits-left count, ready/shift generation).
- FSM, counters and compare logic stay in the top.

Test Plan:
- CHAIN_LEN=10, W=8; load words 0xA5, 0xC0 with cfg_valid held -> exactly 10 shift_en cycles with head sequence 1,0,1,0,0,1,0,1,1,1; done=1 one cycle after the 10th shift; 2 words accepted.
- Same load, source drops cfg_valid for 3 cycles between words -> shift_en low for those cycles; bit sequence unchanged; still 10 shifts total.
- After that load, verify with 0xA5,0xC0 -> mismatch_cnt=0, err_mismatch=0; a further verify pass still passes (chain preserved).
- Verify with 0xA4,0xC0 -> err_mismatch=1, mismatch_cnt=1; with 0x5A,0x3F -> mismatch_cnt=10.
- Back-to-back: CHAIN_LEN=16, W=8, words always valid -> 16 consecutive shift_en cycles, no bubble; cfg_ready high in the cycle of shift 8.
- abort after 5 shifts -> IDLE next cycle, cfg_ready=0, shift_en=0, done=0; pReset_n low mid-LOAD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned CHAIN_LEN_DEF = 64;
  localparam int unsigned W_DEF         = 32;
  localparam int unsigned CNT_W_DEF     = 16;

  // Bit counter must hold the value CHAIN_LEN itself.
  function automatic int unsigned bit_cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  function automatic int unsigned words_per_pass(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

  // Bits of the last word that land in the chain; the remainder is discarded.
  function automatic int unsigned final_word_bits(input int unsigned len, input int unsigned w);
    return ((len % w) == 0) ? w : (len % w);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// W-bit word buffer that streams MSB-first, requesting a new word just as the last bit leaves.
module ccff_word_serializer #(
  parameter int unsigned W      = 32,
  parameter int unsigned NEED_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [NEED_W-1:0] need,
  input  logic [W-1:0]      data,
  input  logic              valid,
  output logic              ready_c,
  output logic              shift_c,
  output logic              msb
);

  localparam int unsigned LEFT_W = $clog2(W + 1);
  localparam int unsigned CMP_W  = (LEFT_W > NEED_W) ? LEFT_W : NEED_W;

  logic [W-1:0]      buffer;
  logic [LEFT_W-1:0] left;

  assign shift_c = enable && (left != '0) && (need != '0);
  // Only ask for a word while the chain still needs bits beyond those held here.
  assign ready_c = enable
                && ((left == '0) || ((left == LEFT_W'(1)) && shift_c))
                && (CMP_W'(need) > CMP_W'(left));
  assign msb = buffer[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      left   <= '0;
    end else if (clear) begin
      buffer <= '0;
      left   <= '0;
    end else if (valid && ready_c) begin
      buffer <= data;
      left   <= LEFT_W'(W);
    end else if (shift_c) begin
      buffer <= {buffer[W-2:0], 1'b0};
      left   <= left - LEFT_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads or non-destructively verifies a tile's ccff chain from a valid/ready bitstream.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned W         = W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic             start,
  input  logic             mode_verify,
  input  logic             abort,
  input  logic [W-1:0]     cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             err_mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int unsigned BCNT_W = bit_cnt_width(CHAIN_LEN);

  state_t            state, state_nx;
  logic [BCNT_W-1:0] bit_cnt;
  logic [BCNT_W-1:0] need;
  logic              shift;
  logic              ser_msb;
  logic              ser_clear;
  logic              pass_start;
  logic              last_shift;

  assign need = BCNT_W'(CHAIN_LEN) - bit_cnt;

  ccff_word_serializer #(
    .W      (W),
    .NEED_W (BCNT_W)
  ) u_ser (
    .clk     (prog_clk),
    .rst_n   (pReset_n),
    .clear   (ser_clear),
    .enable  (busy),
    .need    (need),
    .data    (cfg_data),
    .valid   (cfg_valid),
    .ready_c (cfg_ready),
    .shift_c (shift),
    .msb     (ser_msb)
  );

  assign ccff_shift_en = shift;
  // Verify rotates the chain so its contents survive the pass.
  assign ccff_head = (state == VERIFY) ? ccff_tail : ser_msb;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == LOAD) || (state_nx == VERIFY);
      done  <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx   = state;
    pass_start = 1'b0;
    ser_clear  = 1'b0;
    last_shift = shift && (bit_cnt == BCNT_W'(CHAIN_LEN - 1));
    if (abort) begin
      state_nx  = IDLE;
      ser_clear = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx   = mode_verify ? VERIFY : LOAD;
            pass_start = 1'b1;
            ser_clear  = 1'b1;
          end
        end
        LOAD, VERIFY: begin
          // Leftover bits of a partial final word are flushed here.
          if (last_shift) begin
            state_nx  = DONE;
            ser_clear = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      bit_cnt      <= '0;
      err_mismatch <= 1'b0;
      mismatch_cnt <= '0;
    end else if (pass_start) begin
      bit_cnt      <= '0;
      err_mismatch <= 1'b0;
      mismatch_cnt <= '0;
    end else if (shift) begin
      bit_cnt <= bit_cnt + BCNT_W'(1);
      if ((state == VERIFY) && (ccff_tail != ser_msb)) begin
        err_mismatch <= 1'b1;
        if (mismatch_cnt != '1) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: stimulus queues expected pass results, a negedge monitor compares them.
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

  localparam int unsigned LEN     = 10;
  localparam int unsigned W       = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned NW      = words_per_pass(LEN, W);
  localparam int unsigned SB      = NW * W;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             prog_clk = 1'b0;
  logic             pReset_n = 1'b1;
  logic             start = 1'b0;
  logic             mode_verify = 1'b0;
  logic             abort = 1'b0;
  logic [W-1:0]     cfg_data = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic             busy, done, err_mismatch;
  logic [CNT_W-1:0] mismatch_cnt;

  // Physical chain stand-in with arbitrary power-up contents.
  logic [LEN-1:0] chain = 10'b1100101011;

  ccff_chain_loader #(.CHAIN_LEN(LEN), .W(W), .CNT_W(CNT_W)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .mode_verify   (mode_verify),
    .abort         (abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err_mismatch  (err_mismatch),
    .mismatch_cnt  (mismatch_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[LEN-2:0], ccff_head};
  assign ccff_tail = chain[LEN-1];

  typedef struct {
    logic [LEN-1:0] bits;      // bits[i] = expected ccff_head on the i-th shift
    int             words;
    int             mm;
    logic           err;
    logic           nobubble;
  } pass_t;

  pass_t pass_q[$];
  int checks = 0;
  int passed = 0;

  // Reference: what the chain should hold, bits[i] = i-th bit shifted in.
  logic [LEN-1:0] chain_ref = '0;
  logic           chain_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_shift_en"}, ccff_shift_en, 0);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_err"}, err_mismatch, 0);
    check({tag, "_mm_cnt"}, mismatch_cnt, 0);
  endtask

  // Monitor: pops a pass record when busy rises, checks every shift and the DONE result.
  pass_t cur;
  logic  active = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_shift = 1'b0;
  int    idx = 0, acc = 0, first_cyc = -1, last_cyc = 0, cyc = 0;

  always @(negedge prog_clk) begin
    cyc++;
    if (busy && !prev_busy) begin
      if (pass_q.size() == 0) check("unexpected_pass", pass_q.size(), 1);
      else begin
        cur = pass_q.pop_front();
        active = 1'b1; idx = 0; acc = 0; first_cyc = -1;
      end
    end
    if (active) begin
      if (cfg_valid && cfg_ready) acc++;
      if (ccff_shift_en) begin
        if (idx < LEN) check($sformatf("head_bit%0d", idx), ccff_head, cur.bits[idx]);
        else check("extra_shift", idx, LEN - 1);
        if (cur.nobubble && idx == W - 1) check("ready_at_word_end", cfg_ready, 1);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end
      if (done && !prev_done) begin
        check("shift_count", idx, LEN);
        check("done_after_last_shift", prev_shift, 1);
        check("words_accepted", acc, cur.words);
        check("mismatch_cnt", mismatch_cnt, cur.mm);
        check("err_mismatch", err_mismatch, cur.err);
        if (cur.nobubble) check("no_bubble_span", last_cyc - first_cyc + 1, LEN);
        active = 1'b0;
      end else if (!busy && !done) begin
        active = 1'b0;
      end
    end
    prev_busy  = busy;
    prev_done  = done;
    prev_shift = ccff_shift_en;
  end

  task automatic pulse_start(input logic verify);
    tick();
    start = 1'b1; mode_verify = verify;
    tick();
    start = 1'b0; mode_verify = 1'b0;
  endtask

  // One complete pass; gap < 0 picks a random stall before each later word.
  task automatic run_pass(input logic verify, input logic [SB-1:0] ws, input int gap,
                          input logic nobubble);
    pass_t r;
    int    mm, t, g;
    mm = 0;
    for (int i = 0; i < LEN; i++) begin
      if (verify) begin
        r.bits[i] = chain_ref[i];
        if (chain_ref[i] != ws[SB-1-i]) mm++;
      end else begin
        r.bits[i] = ws[SB-1-i];
      end
    end
    r.words = NW;
    r.mm = (mm > CNT_MAX) ? CNT_MAX : mm;
    r.err = (mm != 0);
    r.nobubble = nobubble;
    pass_q.push_back(r);
    pulse_start(verify);
    for (int k = 0; k < NW; k++) begin
      if (k > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        cfg_valid = 1'b0;
        repeat (g) tick();
      end
      cfg_valid = 1'b1;
      cfg_data = ws[SB-1-k*W -: W];
      t = 0;
      while (!cfg_ready && t < 100) begin tick(); t++; end
      if (!cfg_ready) check("word_accept_timeout", cfg_ready, 1);
      tick();
    end
    // Keep offering surplus words; none may be taken.
    cfg_data = W'($urandom);
    t = 0;
    while (!done && t < 100) begin tick(); t++; end
    check("pass_done", done, 1);
    cfg_valid = 1'b0;
    if (!verify) begin
      for (int i = 0; i < LEN; i++) chain_ref[i] = ws[SB-1-i];
      chain_known = 1'b1;
    end
  endtask

  // Starts a load of all-ones words and returns once n shifts have been seen.
  task automatic partial_load(input int stop_at, input logic poke_start);
    pass_t r;
    int    n, t;
    r.bits = '1; r.words = NW; r.mm = 0; r.err = 1'b0; r.nobubble = 1'b0;
    pass_q.push_back(r);
    pulse_start(1'b0);
    cfg_valid = 1'b1;
    cfg_data = '1;
    n = 0; t = 0;
    while (t < 100) begin
      if (ccff_shift_en) n++;
      if (n == stop_at) break;
      start = poke_start && (n == 2);
      mode_verify = poke_start && (n == 2);
      tick();
      t++;
    end
    start = 1'b0; mode_verify = 1'b0;
    check("shifts_before_interrupt", n, stop_at);
  endtask

  initial begin
    logic [SB-1:0] ws;
    #2 pReset_n = 1'b0;
    #2 check_idle("reset");
    tick(); tick();
    pReset_n = 1'b1;

    run_pass(1'b0, 16'hA5C0, 0, 1'b1);
    run_pass(1'b0, 16'hA5C0, 3, 1'b0);
    run_pass(1'b1, 16'hA5C0, 0, 1'b0);
    run_pass(1'b1, 16'hA5C0, 2, 1'b0);
    run_pass(1'b1, 16'hA4C0, 0, 1'b0);
    run_pass(1'b1, 16'h5A3F, 0, 1'b0);

    // Abort after 5 shifts, with an ignored start while busy.
    partial_load(5, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0; cfg_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cfg_ready", cfg_ready, 0);
    check("abort_shift_en", ccff_shift_en, 0);
    check("abort_done", done, 0);
    chain_known = 1'b0;

    // start together with abort stays idle.
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);

    // Asynchronous reset in the middle of a load.
    partial_load(3, 1'b0);
    #1 pReset_n = 1'b0;
    #1 check_idle("mid_reset");
    cfg_valid = 1'b0;
    tick(); tick();
    pReset_n = 1'b1;

    run_pass(1'b0, 16'h3B6D, -1, 1'b0);
    for (int p = 0; p < 12; p++) begin
      logic verify;
      verify = chain_known && ($urandom_range(0, 1) == 1);
      ws = SB'($urandom);
      if (verify && ($urandom_range(0, 1) == 1)) begin
        for (int i = 0; i < LEN; i++) ws[SB-1-i] = chain_ref[i];
        if ($urandom_range(0, 1) == 1) ws[SB-1-int'($urandom_range(0, LEN-1))] ^= 1'b1;
      end
      run_pass(verify, ws, -1, 1'b0);
    end

    tick(); tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
